// File: rtl/tx_ctrl_pkg.sv
// Shared types for the TX LO sweep controller.
// The descriptor struct is sized for the default phase and dwell widths.
package tx_ctrl_pkg;

  localparam int PHASE_W_DEF = 16;
  localparam int DWELL_W_DEF = 32;
  localparam logic [4:0] OSEL_MUTE = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DWELL,
    ST_DONE
  } sweep_state_t;

  typedef struct packed {
    logic [PHASE_W_DEF-1:0] start;
    logic [PHASE_W_DEF-1:0] stop;
    logic [PHASE_W_DEF-1:0] step;
    logic [DWELL_W_DEF-1:0] dwell;
    logic                   cont;
    logic [4:0]             osel;
  } sweep_desc_t;

endpackage

// File: rtl/tx_dwell_timer.sv
// Loadable down-counter; expire pulses while enabled at count zero.
module tx_dwell_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  assign expire = en & ~load & (count_q == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/tx_lo_sweep_ctrl.sv
// TX LO sweep sequencer: steps the DDS phase increment from start to stop,
// blanking the DAC for a settle period and holding each point for a dwell.
module tx_lo_sweep_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int PHASE_W       = PHASE_W_DEF,
  parameter int DWELL_W       = DWELL_W_DEF,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_start_inc,
  input  logic [PHASE_W-1:0] cfg_stop_inc,
  input  logic [PHASE_W-1:0] cfg_step_inc,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_continuous,
  input  logic [4:0]         cfg_output_select,
  input  logic               abort,
  output logic [PHASE_W-1:0] lo_dds_phase_inc,
  output logic [4:0]         output_select,
  output logic               dds_enable,
  output logic               settle,
  output logic               busy,
  output logic               step_strobe,
  output logic               done
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES - 1);

  sweep_state_t state_q, state_d;
  sweep_desc_t  desc_q, desc_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [4:0] osel_q, osel_d;
  logic dds_q, dds_d;
  logic settle_q, settle_d;
  logic strobe_q, strobe_d;
  logic done_q, done_d;

  logic s_load, s_en, s_exp;
  logic d_load, d_en, d_exp;
  logic [PHASE_W-1:0] start_w, stop_w, step_w;
  logic [DWELL_W-1:0] dwell_w, dwell_ld;
  logic [PHASE_W:0] next_sum;
  logic last_pt;

  assign start_w  = PHASE_W'(desc_q.start);
  assign stop_w   = PHASE_W'(desc_q.stop);
  assign step_w   = PHASE_W'(desc_q.step);
  assign dwell_w  = DWELL_W'(desc_q.dwell);
  assign dwell_ld = (dwell_w == '0) ? '0 : dwell_w - 1'b1;

  // Extra carry bit catches a wrap past the top of the increment range.
  assign next_sum = {1'b0, phase_q} + {1'b0, step_w};
  assign last_pt  = (step_w == '0) | next_sum[PHASE_W]
                  | (next_sum[PHASE_W-1:0] > stop_w);

  always_comb begin
    state_d  = state_q;
    desc_d   = desc_q;
    phase_d  = phase_q;
    osel_d   = osel_q;
    dds_d    = dds_q;
    settle_d = settle_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    s_load   = 1'b0;
    d_load   = 1'b0;
    s_en     = (state_q == ST_SETTLE);
    d_en     = (state_q == ST_DWELL);
    if (abort) begin
      state_d  = ST_IDLE;
      dds_d    = 1'b0;
      osel_d   = OSEL_MUTE;
      settle_d = 1'b0;
      s_en     = 1'b0;
      d_en     = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_valid) begin
            desc_d.start = PHASE_W_DEF'(cfg_start_inc);
            desc_d.stop  = PHASE_W_DEF'(cfg_stop_inc);
            desc_d.step  = PHASE_W_DEF'(cfg_step_inc);
            desc_d.dwell = DWELL_W_DEF'(cfg_dwell);
            desc_d.cont  = cfg_continuous;
            desc_d.osel  = cfg_output_select;
            phase_d  = cfg_start_inc;
            strobe_d = 1'b1;
            settle_d = 1'b1;
            dds_d    = 1'b1;
            osel_d   = OSEL_MUTE;
            s_load   = 1'b1;
            state_d  = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (s_exp) begin
            settle_d = 1'b0;
            osel_d   = desc_q.osel;
            d_load   = 1'b1;
            state_d  = ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (d_exp) begin
            if (!last_pt || desc_q.cont) begin
              phase_d  = last_pt ? start_w : next_sum[PHASE_W-1:0];
              strobe_d = 1'b1;
              settle_d = 1'b1;
              osel_d   = OSEL_MUTE;
              s_load   = 1'b1;
              state_d  = ST_SETTLE;
            end else begin
              done_d  = 1'b1;
              dds_d   = 1'b0;
              osel_d  = OSEL_MUTE;
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
      endcase
    end
  end

  tx_dwell_timer #(.W(SW)) u_settle_tmr (
    .clock(clock), .reset(reset), .load(s_load), .en(s_en),
    .load_val(SETTLE_LD), .expire(s_exp)
  );

  tx_dwell_timer #(.W(DWELL_W)) u_dwell_tmr (
    .clock(clock), .reset(reset), .load(d_load), .en(d_en),
    .load_val(dwell_ld), .expire(d_exp)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      desc_q   <= '0;
      phase_q  <= '0;
      osel_q   <= OSEL_MUTE;
      dds_q    <= 1'b0;
      settle_q <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      desc_q   <= desc_d;
      phase_q  <= phase_d;
      osel_q   <= osel_d;
      dds_q    <= dds_d;
      settle_q <= settle_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign cfg_ready        = (state_q == ST_IDLE) & ~abort & ~reset;
  assign lo_dds_phase_inc = phase_q;
  assign output_select    = osel_q;
  assign dds_enable       = dds_q;
  assign settle           = settle_q;
  assign busy             = (state_q != ST_IDLE);
  assign step_strobe      = strobe_q;
  assign done             = done_q;

endmodule

// File: doc/tx_lo_sweep_ctrl.md
# tx_lo_sweep_ctrl

Sequencer for the TX LO path. It accepts a sweep descriptor through a valid/ready handshake and steps the LO DDS phase increment from a start value to a stop value. At each point it blanks the DAC for a programmable settle time, then holds the point for a dwell period. It drives `lo_dds_phase_inc`, `output_select` and the DDS phase-valid of `tx_core`, and sits between the control-register block and `tx_core`.

## Interface
Parameters:
- `PHASE_W`, 16: width of the phase-increment fields.
- `DWELL_W`, 32: width of the dwell counter.
- `SETTLE_CYCLES`, 16: blanking cycles after each increment change; covers the `tx_core` pipeline depth. Legal range is ≥1.

Ports:
- `clock` in 1: single clock, the `tx_core` clock.
- `reset` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: descriptor valid.
- `cfg_ready` out 1: descriptor accepted when high together with `cfg_valid`.
- `cfg_start_inc` in PHASE_W: first phase increment.
- `cfg_stop_inc` in PHASE_W: last allowed phase increment.
- `cfg_step_inc` in PHASE_W: increment step, unsigned.
- `cfg_dwell` in DWELL_W: cycles per point; 0 is treated as 1.
- `cfg_continuous` in 1: 1 restarts the sweep at start after the last point; 0 runs a single sweep.
- `cfg_output_select` in 5: `output_select` value used during dwell.
- `abort` in 1: synchronous abort.
- `lo_dds_phase_inc` out PHASE_W: to `tx_core`.
- `output_select` out 5: to `tx_core`.
- `dds_enable` out 1: DDS phase tvalid.
- `settle` out 1: high during blanking.
- `busy` out 1: state is not IDLE.
- `step_strobe` out 1: one-cycle pulse on every increment load.
- `done` out 1: one-cycle pulse when a single sweep completes.

## Operation
- States are IDLE, SETTLE, DWELL and DONE.
- **Reset values:** all outputs are 0, `cfg_ready`=0 during reset, and the state is IDLE.
- **Handshake:**
  - `cfg_ready` = (state==IDLE) & ~abort.
  - On accept, all cfg fields are latched, `lo_dds_phase_inc`←start, `step_strobe`=1, and the state goes to SETTLE.
- **SETTLE:**
  - `settle`=1, `output_select`=0 (mute), `dds_enable`=1.
  - The settle counter runs SETTLE_CYCLES cycles, then the state goes to DWELL.
- **DWELL:**
  - `settle`=0, `output_select`=latched select.
  - Counts max(cfg_dwell,1) cycles.
- **End of a dwell point:**
  - next = cur + step, computed with PHASE_W+1 bits.
  - If step==0, or next > stop, or the carry bit is set (wrap), the current point is the last one.
  - Not last: `lo_dds_phase_inc`←next, `step_strobe`, state SETTLE.
  - Last and continuous: `lo_dds_phase_inc`←start, `step_strobe`, state SETTLE.
  - Last and single: state DONE.
- **start > stop:** a single point at start, then the last-point rule applies.
- **DONE:**
  - Lasts one cycle.
  - `done`=1, `dds_enable`←0, `output_select`←0, then the state goes to IDLE.
- **abort:**
  - Applies from any state, with priority over every other event.
  - Next state is IDLE; `dds_enable`, `output_select` and `settle` go to 0.
  - `lo_dds_phase_inc` holds its value; `done` is not pulsed.
- **Sweep in progress:** `lo_dds_phase_inc` never changes except by a `step_strobe` load.
- **Mid-operation reset:** asynchronous return to the reset values.

## Timing
- Cycle A is the accept edge.
- `step_strobe`, `busy`, `settle` and `dds_enable` are high from A+1.
- The new `lo_dds_phase_inc` is visible from A+1.
- `settle` stays high for exactly SETTLE_CYCLES cycles.
- Per-point period = SETTLE_CYCLES + max(dwell,1) cycles.
- `step_strobe` marks the first cycle of each SETTLE.
- Single sweep of N points: `done` is high in cycle A+N·period+1.
- `busy` falls and `cfg_ready` rises in the cycle after `done`.
- abort sampled at edge E: outputs reach IDLE values at E+1, and `cfg_ready` can be 1 at E+1 if abort is low.
- All outputs are registered; there are no combinational paths from inputs to outputs except `cfg_ready`←`abort`.

## Structure
- Package `tx_ctrl_pkg` holds:
  - the state enum;
  - the localparam `OSEL_MUTE`=0;
  - a packed struct for the latched descriptor.
- Sub-module `tx_dwell_timer` is a loadable down-counter with an `expire` pulse.
  - It is width-parameterized and used once for settle and once for dwell.

## Test plan
- **Single sweep:** start=100, stop=130, step=10, dwell=4, SETTLE=16.
  - Required: increments 100/110/120/130.
  - Required: 4 `step_strobe` pulses 20 cycles apart.
  - Required: `done` at A+81.
- **Continuous sweep:** same descriptor with `cfg_continuous`=1.
  - Required: after 130 the increment reloads to 100.
  - Required: `done` never pulses.
  - Required: `busy` stays high until abort.
- **Wrap:** start=0xFFF0, stop=0xFFFF, step=0x20, dwell=0.
  - Required: a single point at 0xFFF0 dwelling 1 cycle, then `done`.
  - Required: no wrap to 0x0010.
- **Step zero and start > stop:**
  - step=0: a single point.
  - start=500, stop=200: a single point at 500.
  - Required in both cases: `done` after one period.
- **Abort during DWELL:**
  - Required: IDLE the next cycle, `dds_enable`=0, `output_select`=0, `lo_dds_phase_inc` held, no `done`.
  - Abort coincident with `cfg_valid` in IDLE: `cfg_ready`=0 and no accept.
- **Reset asserted mid-SETTLE:**
  - Required: all outputs 0 asynchronously.
  - Required: after release, `cfg_ready`=1 and a new descriptor runs normally.
